// File: rtl/instr_fetch.sv
// Fetch stage between the 1-cycle synchronous program ROM and decode: issues ROM reads,
// buffers up to two words behind a valid/ready handshake, and flushes on redirects.
// Optional performance counters are enabled by defining IFETCH_PERF_CNT_EN.
`ifndef CODE_ADDR_WIDTH
`define CODE_ADDR_WIDTH 13
`endif

module instr_fetch #(
    parameter int                    ADDR_WIDTH = `CODE_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [15:0]           rom_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [15:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] issue_pc;
    logic                  inflight;

    logic                  out_valid;
    logic [15:0]           out_word;
    logic [ADDR_WIDTH-1:0] out_pc;

    logic                  skid_valid;
    logic [15:0]           skid_word;
    logic [ADDR_WIDTH-1:0] skid_pc;

    logic                  fire;
    logic                  issue;
    logic                  capture;
    logic                  cap_to_out;
    logic [1:0]            occupancy;

    // occupancy never exceeds 2 because issue is throttled, so 2 bits are enough
    always_comb begin
        fire       = out_valid & instr_ready;
        rom_addr   = redirect_valid ? redirect_addr : pc;
        occupancy  = 2'(out_valid) + 2'(skid_valid) + 2'(inflight) - 2'(fire);
        issue      = !halt && (redirect_valid || (occupancy < 2'd2));
        capture    = inflight & !redirect_valid;
        cap_to_out = !out_valid || (fire && !skid_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            issue_pc   <= '0;
            inflight   <= 1'b0;
            out_valid  <= 1'b0;
            out_word   <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_word  <= '0;
            skid_pc    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc       <= rom_addr + ADDR_WIDTH'(1);
                issue_pc <= rom_addr;
            end else if (redirect_valid) begin
                pc <= redirect_addr;
            end

            if (redirect_valid) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else begin
                if (capture && cap_to_out) begin
                    out_valid <= 1'b1;
                    out_word  <= rom_data;
                    out_pc    <= issue_pc;
                end else if (fire) begin
                    if (skid_valid) begin
                        out_word <= skid_word;
                        out_pc   <= skid_pc;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end

                // older skid entry moves forward before the new word lands behind it
                if (capture && !cap_to_out) begin
                    skid_valid <= 1'b1;
                    skid_word  <= rom_data;
                    skid_pc    <= issue_pc;
                end else if (fire) begin
                    skid_valid <= 1'b0;
                end
            end
        end
    end

    assign instr_valid = out_valid;
    assign instr       = out_word;
    assign instr_pc    = out_pc;

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid && !instr_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && out_valid && skid_valid));
`endif

endmodule
